// File: rtl/debug_chan_arb_if.sv
// rtl/debug_chan_arb_if.sv - client-side and PHY-side FIFO handshake bundle for debug_chan_arb
// master is the arbiter's view; slave is the environment (clients plus PHY).
interface debug_chan_arb_if #(
    parameter int NCH    = 4,
    parameter int CMD_W  = 36,
    parameter int RESP_W = 35
);
    logic [NCH*CMD_W-1:0]  ch_wrdata;
    logic [NCH-1:0]        ch_wren;
    logic [NCH-1:0]        ch_wrfull;
    logic [NCH*RESP_W-1:0] ch_rddata;
    logic [NCH-1:0]        ch_rden;
    logic [NCH-1:0]        ch_rdempty;
    logic [CMD_W-1:0]      phy_wrdata;
    logic                  phy_wren;
    logic                  phy_wrfull;
    logic [RESP_W-1:0]     phy_rddata;
    logic                  phy_rden;
    logic                  phy_rdempty;

    modport master (
        input  ch_wrdata, ch_wren, ch_rden, phy_wrfull, phy_rddata, phy_rdempty,
        output ch_wrfull, ch_rddata, ch_rdempty, phy_wrdata, phy_wren, phy_rden
    );

    modport slave (
        output ch_wrdata, ch_wren, ch_rden, phy_wrfull, phy_rddata, phy_rdempty,
        input  ch_wrfull, ch_rddata, ch_rdempty, phy_wrdata, phy_wren, phy_rden
    );
endinterface

// File: rtl/debug_chan_arb.sv
// rtl/debug_chan_arb.sv - NCH-client command/response arbiter onto one PHY FIFO pair
// Exclusive or round-robin grant, tag FIFO routes responses home, cfg changes drain first.
module debug_chan_arb #(
    parameter int NCH     = 4,
    parameter int CMD_W   = 36,
    parameter int RESP_W  = 35,
    parameter int MAX_OUT = 4,
    parameter int BURST   = 4,
    localparam int SW     = $clog2(NCH)
) (
    input  logic          clk_i,
    input  logic          reset_i,
    input  logic [SW-1:0] sel_i,
    input  logic          arb_mode_i,
    debug_chan_arb_if.master bus,
    output logic [SW-1:0] cur_sel_o,
    output logic          cur_mode_o,
    output logic          cfg_busy_o,
    output logic          err_unsol_o
);
    localparam int AW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
    localparam int OW = $clog2(MAX_OUT + 1);
    localparam int BW = $clog2(BURST + 1);

    typedef enum logic {RUN, DRAIN} state_t;

    state_t              state_q;
    logic                cfg_busy_q;
    logic [SW-1:0]       act_sel_q;
    logic                act_mode_q;
    logic [SW-1:0]       grant_q;
    logic [BW-1:0]       burst_q;
    logic [OW-1:0]       outst_q;
    logic [OW-1:0]       outst_d;
    logic [SW-1:0]       tag_q [2**AW];
    logic [AW-1:0]       wr_ptr_q;
    logic [AW-1:0]       rd_ptr_q;
    logic [NCH-1:0]      valid_q;
    logic [RESP_W-1:0]   resp_q [NCH];
    logic                err_q;

    logic                can_issue;
    logic                wr_acc;
    logic                tag_empty;
    logic                pop;
    logic                unsol;
    logic                cfg_diff;
    logic [SW-1:0]       head;
    logic [SW-1:0]       grant_inc;

    // Tag FIFO occupancy always equals the outstanding count.
    assign tag_empty = (outst_q == '0);
    assign head      = tag_q[rd_ptr_q];
    assign can_issue = (state_q == RUN) && !bus.phy_wrfull && (outst_q < OW'(MAX_OUT));
    assign wr_acc    = can_issue && bus.ch_wren[grant_q];
    assign grant_inc = (grant_q == SW'(NCH - 1)) ? '0 : grant_q + 1'b1;

    assign bus.phy_wren   = wr_acc;
    assign bus.phy_wrdata = bus.ch_wrdata[int'(grant_q)*CMD_W +: CMD_W];
    assign bus.phy_rden   = !bus.phy_rdempty && (tag_empty || !valid_q[head] || bus.ch_rden[head]);
    assign pop            = bus.phy_rden && !tag_empty;
    assign unsol          = bus.phy_rden && tag_empty;
    assign outst_d        = outst_q + OW'(wr_acc) - OW'(pop);

    // Round-robin ignores SEL; exclusive cares about SEL and a mode flip.
    assign cfg_diff = act_mode_q ? !arb_mode_i : (arb_mode_i || (sel_i != act_sel_q));

    always_comb begin
        bus.ch_wrfull = '1;
        for (int i = 0; i < NCH; i++) begin
            if (can_issue && (grant_q == SW'(i))) begin
                bus.ch_wrfull[i] = 1'b0;
            end
        end
    end

    always_comb begin
        bus.ch_rddata = '0;
        for (int i = 0; i < NCH; i++) begin
            bus.ch_rddata[i*RESP_W +: RESP_W] = resp_q[i];
        end
    end

    assign bus.ch_rdempty = ~valid_q;
    assign cur_sel_o      = act_sel_q;
    assign cur_mode_o     = act_mode_q;
    assign cfg_busy_o     = cfg_busy_q;
    assign err_unsol_o    = err_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= RUN;
            cfg_busy_q <= 1'b0;
            act_sel_q  <= '0;
            act_mode_q <= 1'b0;
            grant_q    <= '0;
            burst_q    <= '0;
            outst_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            valid_q    <= '0;
            err_q      <= 1'b0;
            for (int i = 0; i < NCH; i++) begin
                resp_q[i] <= '0;
            end
        end else begin
            outst_q <= outst_d;
            if (wr_acc) begin
                tag_q[wr_ptr_q] <= grant_q;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (unsol) begin
                err_q <= 1'b1;
            end
            // A refill in the same cycle as a client read wins, keeping valid set.
            for (int i = 0; i < NCH; i++) begin
                if (pop && (head == SW'(i))) begin
                    resp_q[i]  <= bus.phy_rddata;
                    valid_q[i] <= 1'b1;
                end else if (bus.ch_rden[i]) begin
                    valid_q[i] <= 1'b0;
                end
            end
            case (state_q)
                RUN: begin
                    if (cfg_diff) begin
                        state_q    <= DRAIN;
                        cfg_busy_q <= 1'b1;
                    end
                    if (act_mode_q && can_issue) begin
                        if (!wr_acc || (burst_q == BW'(BURST - 1))) begin
                            grant_q <= grant_inc;
                            burst_q <= '0;
                        end else begin
                            burst_q <= burst_q + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (outst_q == '0) begin
                        state_q    <= RUN;
                        cfg_busy_q <= 1'b0;
                        act_sel_q  <= sel_i;
                        act_mode_q <= arb_mode_i;
                        burst_q    <= '0;
                        if (!arb_mode_i) begin
                            grant_q <= sel_i;
                        end
                    end
                end
                default: state_q <= RUN;
            endcase
        end
    end
endmodule

// File: tb/tb_debug_chan_arb.sv
// tb/tb_debug_chan_arb.sv - directed self-checking bench for debug_chan_arb
// Exclusive stream via vector table, then hand sequences for limit, round-robin, drain, unsolicited and reset.
module tb_debug_chan_arb;
    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] sel;
    logic       mode;
    logic [1:0] cur_sel;
    logic       cur_mode;
    logic       busy;
    logic       err;

    int checks   = 0;
    int failures = 0;

    debug_chan_arb_if #(.NCH(4), .CMD_W(36), .RESP_W(35)) bus ();

    debug_chan_arb #(
        .NCH(4), .CMD_W(36), .RESP_W(35), .MAX_OUT(4), .BURST(4)
    ) dut (
        .clk_i      (clk),
        .reset_i    (rst),
        .sel_i      (sel),
        .arb_mode_i (mode),
        .bus        (bus.master),
        .cur_sel_o  (cur_sel),
        .cur_mode_o (cur_mode),
        .cfg_busy_o (busy),
        .err_unsol_o(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  sel;
        logic [3:0]  wren;
        logic [3:0]  rden;
        logic        pempty;
        logic [34:0] rdata;
        logic [3:0]  x_wrfull;
        logic        x_wren;
        logic        x_rden;
        logic [3:0]  x_rdempty;
        logic        x_busy;
        logic [1:0]  x_cursel;
        logic [34:0] x_rd2;
    } vec_t;

    vec_t tbl [11];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [35:0] wd(input int ch, input int tag);
        return {4'(ch), 32'(tag)};
    endfunction

    function automatic logic [34:0] rd(input int ch);
        return bus.ch_rddata[ch*35 +: 35];
    endfunction

    task automatic set_wdata(input int tag);
        for (int i = 0; i < 4; i++) begin
            bus.ch_wrdata[i*36 +: 36] = wd(i, tag);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL timeout simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [34:0] r0;
        int c;
        r0 = 35'h1_2345_6700;
        //            sel   wren     rden     pe   rdata   x_wrfull x_wren x_rden x_rdempty x_busy x_cursel x_rd2
        tbl[0]  = '{2'd0, 4'b0000, 4'b0000, 1'b1, 35'd0,  4'b1110, 1'b0, 1'b0, 4'b1111, 1'b0, 2'd0, 35'd0};
        tbl[1]  = '{2'd2, 4'b0000, 4'b0000, 1'b1, 35'd0,  4'b1110, 1'b0, 1'b0, 4'b1111, 1'b0, 2'd0, 35'd0};
        tbl[2]  = '{2'd2, 4'b0000, 4'b0000, 1'b1, 35'd0,  4'b1111, 1'b0, 1'b0, 4'b1111, 1'b1, 2'd0, 35'd0};
        tbl[3]  = '{2'd2, 4'b0100, 4'b0000, 1'b1, 35'd0,  4'b1011, 1'b1, 1'b0, 4'b1111, 1'b0, 2'd2, 35'd0};
        tbl[4]  = '{2'd2, 4'b0100, 4'b0000, 1'b0, r0+0,   4'b1011, 1'b1, 1'b1, 4'b1111, 1'b0, 2'd2, 35'd0};
        tbl[5]  = '{2'd2, 4'b0100, 4'b0100, 1'b0, r0+1,   4'b1011, 1'b1, 1'b1, 4'b1011, 1'b0, 2'd2, r0+0};
        tbl[6]  = '{2'd2, 4'b0100, 4'b0100, 1'b0, r0+2,   4'b1011, 1'b1, 1'b1, 4'b1011, 1'b0, 2'd2, r0+1};
        tbl[7]  = '{2'd2, 4'b0100, 4'b0100, 1'b0, r0+3,   4'b1011, 1'b1, 1'b1, 4'b1011, 1'b0, 2'd2, r0+2};
        tbl[8]  = '{2'd2, 4'b0000, 4'b0100, 1'b0, r0+4,   4'b1011, 1'b0, 1'b1, 4'b1011, 1'b0, 2'd2, r0+3};
        tbl[9]  = '{2'd2, 4'b0000, 4'b0100, 1'b1, 35'd0,  4'b1011, 1'b0, 1'b0, 4'b1011, 1'b0, 2'd2, r0+4};
        tbl[10] = '{2'd2, 4'b0000, 4'b0000, 1'b1, 35'd0,  4'b1011, 1'b0, 1'b0, 4'b1111, 1'b0, 2'd2, r0+4};

        rst = 1'b1; sel = 2'd0; mode = 1'b0;
        bus.ch_wren = '0; bus.ch_rden = '0; bus.ch_wrdata = '0;
        bus.phy_wrfull = 1'b0; bus.phy_rdempty = 1'b1; bus.phy_rddata = '0;
        tick(); tick();
        rst = 1'b0;
        #2;
        chk("reset err", err, 1'b0);
        chk("reset cur_mode", cur_mode, 1'b0);
        chk("reset rddata", bus.ch_rddata, '0);

        for (int v = 0; v < 11; v++) begin
            sel = tbl[v].sel;
            bus.ch_wren = tbl[v].wren;
            bus.ch_rden = tbl[v].rden;
            bus.phy_rdempty = tbl[v].pempty;
            bus.phy_rddata = tbl[v].rdata;
            set_wdata(v);
            #2;
            chk($sformatf("v%0d wrfull", v), bus.ch_wrfull, tbl[v].x_wrfull);
            chk($sformatf("v%0d phy_wren", v), bus.phy_wren, tbl[v].x_wren);
            chk($sformatf("v%0d phy_rden", v), bus.phy_rden, tbl[v].x_rden);
            chk($sformatf("v%0d rdempty", v), bus.ch_rdempty, tbl[v].x_rdempty);
            chk($sformatf("v%0d busy", v), busy, tbl[v].x_busy);
            chk($sformatf("v%0d cur_sel", v), cur_sel, tbl[v].x_cursel);
            chk($sformatf("v%0d rddata2", v), rd(2), tbl[v].x_rd2);
            if (tbl[v].x_wren) chk($sformatf("v%0d phy_wrdata", v), bus.phy_wrdata, wd(2, v));
            tick();
        end

        // Outstanding limit on ch2
        bus.ch_rden = '0;
        for (int j = 0; j < 4; j++) begin
            bus.ch_wren = 4'b0100; bus.phy_rdempty = 1'b1;
            #2;
            chk($sformatf("lim w%0d wrfull", j), bus.ch_wrfull, 4'b1011);
            chk($sformatf("lim w%0d phy_wren", j), bus.phy_wren, 1'b1);
            tick();
        end
        #2;
        chk("lim 5th wrfull", bus.ch_wrfull, 4'b1111);
        chk("lim 5th phy_wren", bus.phy_wren, 1'b0);
        tick();
        bus.phy_rdempty = 1'b0; bus.phy_rddata = r0 + 5;
        #2;
        chk("lim release rden", bus.phy_rden, 1'b1);
        chk("lim release wrfull", bus.ch_wrfull, 4'b1111);
        tick();
        bus.ch_wren = '0; bus.phy_rdempty = 1'b1;
        #2;
        chk("lim reenable wrfull", bus.ch_wrfull, 4'b1011);
        chk("lim held data", rd(2), r0 + 5);
        for (int j = 0; j < 3; j++) begin
            bus.ch_rden = 4'b0100; bus.phy_rdempty = 1'b0; bus.phy_rddata = r0 + 6 + j;
            #2;
            chk($sformatf("lim drain%0d rden", j), bus.phy_rden, 1'b1);
            tick();
        end
        bus.phy_rdempty = 1'b1;
        tick();
        bus.ch_rden = '0;
        #2;
        chk("lim drained rdempty", bus.ch_rdempty, 4'b1111);
        chk("lim last data", rd(2), r0 + 8);

        // Move to sel 0, then round-robin
        sel = 2'd0;
        tick(); tick();
        #2;
        chk("sel0 cur_sel", cur_sel, 2'd0);
        mode = 1'b1;
        tick(); tick();
        for (int j = 0; j < 17; j++) begin
            bus.ch_wren = 4'hF; bus.ch_rden = 4'hF; set_wdata(100 + j);
            bus.phy_rdempty = (j == 0); bus.phy_rddata = 35'(2000 + j - 1);
            #2;
            if (j == 0) chk("rr cur_mode", cur_mode, 1'b1);
            chk($sformatf("rr%0d phy_wren", j), bus.phy_wren, 1'b1);
            chk($sformatf("rr%0d phy_wrdata", j), bus.phy_wrdata, wd((j / 4) % 4, 100 + j));
            chk($sformatf("rr%0d phy_rden", j), bus.phy_rden, (j > 0));
            if (j >= 2) begin
                c = ((j - 2) / 4) % 4;
                chk($sformatf("rr%0d rdempty", j), bus.ch_rdempty, 4'(~(4'b0001 << c)));
                chk($sformatf("rr%0d rddata", j), rd(c), 35'(2000 + j - 2));
            end
            tick();
        end
        bus.ch_wren = '0; bus.phy_rdempty = 1'b0; bus.phy_rddata = 35'd2016;
        #2;
        chk("rr tail rden", bus.phy_rden, 1'b1);
        chk("rr tail rdempty", bus.ch_rdempty, 4'b0111);
        chk("rr tail rddata", rd(3), 35'd2015);
        tick();
        bus.phy_rdempty = 1'b1;
        #2;
        chk("rr last rdempty", bus.ch_rdempty, 4'b1110);
        chk("rr last rddata", rd(0), 35'd2016);
        tick();
        bus.ch_rden = '0;

        // Exclusive sel 1, 3 outstanding, then switch to sel 3
        mode = 1'b0; sel = 2'd1;
        tick(); tick();
        #2;
        chk("cfg cur_sel1", cur_sel, 2'd1);
        chk("cfg cur_mode0", cur_mode, 1'b0);
        for (int j = 0; j < 3; j++) begin
            bus.ch_wren = 4'b0010; set_wdata(300 + j);
            #2;
            chk($sformatf("cfg w%0d phy_wrdata", j), bus.phy_wrdata, wd(1, 300 + j));
            tick();
        end
        bus.ch_wren = '0; sel = 2'd3;
        #2;
        chk("cfg detect busy", busy, 1'b0);
        tick();
        for (int k = 0; k < 3; k++) begin
            bus.phy_rdempty = 1'b0; bus.phy_rddata = 35'(3000 + k);
            bus.ch_rden = (k > 0) ? 4'b0010 : 4'b0000;
            bus.ch_wren = 4'b1010;
            #2;
            chk($sformatf("cfg pop%0d busy", k), busy, 1'b1);
            chk($sformatf("cfg pop%0d wrfull", k), bus.ch_wrfull, 4'b1111);
            chk($sformatf("cfg pop%0d phy_wren", k), bus.phy_wren, 1'b0);
            chk($sformatf("cfg pop%0d rden", k), bus.phy_rden, 1'b1);
            tick();
        end
        bus.phy_rdempty = 1'b1; bus.ch_rden = '0; bus.ch_wren = '0;
        tick();
        #2;
        chk("cfg done busy", busy, 1'b0);
        chk("cfg done cur_sel", cur_sel, 2'd3);
        chk("cfg done wrfull", bus.ch_wrfull, 4'b0111);
        chk("cfg ch1 rdempty", bus.ch_rdempty, 4'b1101);
        chk("cfg ch1 rddata", rd(1), 35'd3002);
        bus.ch_rden = 4'b0010;
        tick();
        bus.ch_rden = '0;
        #2;
        chk("cfg ch1 read", bus.ch_rdempty, 4'b1111);

        // Unsolicited response
        bus.phy_rdempty = 1'b0; bus.phy_rddata = 35'h7_0000_0000;
        #2;
        chk("unsol rden", bus.phy_rden, 1'b1);
        chk("unsol err before", err, 1'b0);
        tick();
        bus.phy_rdempty = 1'b1;
        #2;
        chk("unsol err set", err, 1'b1);
        chk("unsol rdempty", bus.ch_rdempty, 4'b1111);
        tick(); tick();
        #2;
        chk("unsol err sticky", err, 1'b1);

        // Reset with 2 outstanding and 1 held response on ch3
        for (int j = 0; j < 3; j++) begin
            bus.ch_wren = 4'b1000; set_wdata(400 + j);
            #2;
            chk($sformatf("rst w%0d phy_wren", j), bus.phy_wren, 1'b1);
            tick();
        end
        bus.ch_wren = '0; bus.phy_rdempty = 1'b0; bus.phy_rddata = 35'd4000;
        tick();
        bus.phy_rdempty = 1'b1;
        #2;
        chk("rst held rdempty", bus.ch_rdempty, 4'b0111);
        rst = 1'b1; sel = 2'd0;
        tick();
        rst = 1'b0;
        #2;
        chk("rst rdempty", bus.ch_rdempty, 4'b1111);
        chk("rst rddata3", rd(3), 35'd0);
        chk("rst err", err, 1'b0);
        chk("rst busy", busy, 1'b0);
        chk("rst cur_sel", cur_sel, 2'd0);
        chk("rst wrfull", bus.ch_wrfull, 4'b1110);
        bus.phy_rdempty = 1'b0;
        #2;
        chk("rst late rden", bus.phy_rden, 1'b1);
        tick();
        bus.phy_rdempty = 1'b1;
        #2;
        chk("rst late err", err, 1'b1);
        for (int j = 0; j < 4; j++) begin
            bus.ch_wren = 4'b0001;
            #2;
            chk($sformatf("rst cnt w%0d phy_wren", j), bus.phy_wren, 1'b1);
            tick();
        end
        #2;
        chk("rst cnt 5th wrfull", bus.ch_wrfull, 4'b1111);
        chk("rst cnt 5th phy_wren", bus.phy_wren, 1'b0);
        bus.ch_wren = '0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
